// File: rtl/nios_base_oci_pkg.sv
// Shared types and constants for the Nios OCI data-capture-trace buffer.
package nios_base_oci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam int DCT_W_DEF = 30;
  localparam int CNT_W_DEF = 4;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = n - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_base_oci_sync_fifo.sv
// Synchronous FIFO with a registered head word and registered valid flag.
module nios_base_oci_sync_fifo
  import nios_base_oci_pkg::*;
#(
  parameter int W     = 30,
  parameter int DEPTH = 16,
  localparam int AW   = clog2_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          hold,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic          full,
  output logic          empty_nxt,
  output logic [AW:0]   level
);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic         empty_s, do_push_s, do_pop_s;
  logic [W-1:0] head_s;

  // Pointer arithmetic, full/empty decode and next head selection (with write bypass)
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_s  = wr_ptr_r + {{AW{1'b0}}, do_push_s};
    rd_ptr_s  = rd_ptr_r + {{AW{1'b0}}, do_pop_s};
    empty_nxt = (wr_ptr_s == rd_ptr_s);
    if (do_push_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_ptr_s[AW-1:0]];
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Pointers, occupancy and registered head/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level    <= '0;
      dout     <= '0;
      valid    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      level    <= level + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
      dout     <= head_s;
      valid    <= !empty_nxt && !hold;
    end
  end

endmodule

// File: rtl/nios_base_oci_dct_capture.sv
// OCI data-capture-trace buffer: sample detect, capture FSM, overflow count.
// Optional per-word even parity when NIOS_OCI_DCT_PARITY_EN is defined.
module nios_base_oci_dct_capture
  import nios_base_oci_pkg::*;
#(
  parameter int DCT_W = DCT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 16,
  parameter int OVF_W = 8,
  localparam int AW   = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DCT_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0] dct_count,
  input  logic             test_ending,
  input  logic             test_has_ended,
`ifdef NIOS_OCI_DCT_PARITY_EN
  output logic [DCT_W:0]   rd_data,
  output logic             parity_err,
`else
  output logic [DCT_W-1:0] rd_data,
`endif
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW:0]      fill_level,
  output logic [OVF_W-1:0] overflow_cnt,
  output logic             flush_done,
  output logic [1:0]       state_o
);

`ifdef NIOS_OCI_DCT_PARITY_EN
  localparam int FW = DCT_W + 1;
`else
  localparam int FW = DCT_W;
`endif

  state_e           state_r, state_n;
  logic [CNT_W-1:0] prev_count_r;
  logic             new_sample_s, pop_s, overflow_s, full_s, empty_nxt_s;
  logic [FW-1:0]    fifo_din_s;

`ifdef NIOS_OCI_DCT_PARITY_EN
  function automatic logic even_par_f(input logic [DCT_W-1:0] d);
    return ^d;
  endfunction

  assign fifo_din_s = {even_par_f(dct_buffer), dct_buffer};
`else
  assign fifo_din_s = dct_buffer;
`endif

  // A sample coinciding with test_ending is discarded outright, not counted as overflow
  always_comb begin
    new_sample_s = (state_r == ST_RUN) && !test_ending && (dct_count != prev_count_r);
    pop_s        = rd_valid && rd_ready;
    overflow_s   = new_sample_s && full_s && !pop_s;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; HALT has priority and is left only by reset
  always_comb begin
    state_n = state_r;
    if (test_has_ended) begin
      state_n = ST_HALT;
    end else begin
      case (state_r)
        ST_IDLE:  state_n = ST_RUN;
        ST_RUN:   state_n = test_ending ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_n = ST_FLUSH;
        ST_HALT:  state_n = ST_HALT;
        default:  state_n = ST_HALT;
      endcase
    end
  end

  // Output process: debug state view
  always_comb begin
    state_o = state_r;
  end

  // Count history, saturating overflow counter and sticky flush-done flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_count_r <= '0;
      overflow_cnt <= '0;
      flush_done   <= 1'b0;
    end else begin
      if (state_r != ST_HALT) begin
        prev_count_r <= dct_count;
      end
      if (overflow_s && (overflow_cnt != {OVF_W{1'b1}})) begin
        overflow_cnt <= overflow_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
      end
      if ((state_n == ST_FLUSH) && empty_nxt_s) begin
        flush_done <= 1'b1;
      end
    end
  end

`ifdef NIOS_OCI_DCT_PARITY_EN
  // A stored word including its parity bit must XOR to zero when popped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= pop_s && (^rd_data);
    end
  end
`endif

  nios_base_oci_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (new_sample_s),
    .pop       (pop_s),
    .hold      (state_n == ST_HALT),
    .din       (fifo_din_s),
    .dout      (rd_data),
    .valid     (rd_valid),
    .full      (full_s),
    .empty_nxt (empty_nxt_s),
    .level     (fill_level)
  );

endmodule

// File: doc/nios_base_oci_dct_capture.md
Name: nios_base_oci_dct_capture

Overview:
- Parametrised data-capture-trace (DCT) buffer for the Nios OCI debug path.
- Samples the OCI `dct_buffer` word whenever `dct_count` advances and queues each sample in a DEPTH-entry FIFO.
- Drains the FIFO to a valid/ready consumer: a JTAG trace reader or a testbench checker.
- Sequences end-of-test: stop capture, flush, signal done.

Parameters:
- DCT_W, 30, width of one trace word.
- CNT_W, 4, width of `dct_count`.
- DEPTH, 16, FIFO entries; power of two, range 2..256.
- OVF_W, 8, overflow-counter width; the counter saturates.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dct_buffer  in  DCT_W  trace word from OCI.
- dct_count  in  CNT_W  OCI trace counter; any change denotes one new word.
- test_ending  in  1  request to stop capture and flush (level).
- test_has_ended  in  1  hard stop: freeze all state (level).
- rd_data  out  DCT_W(+1 with parity)  head-of-FIFO word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts.
- fill_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow_cnt  out  OVF_W  samples dropped while full; saturating.
- flush_done  out  1  FIFO empty after a flush.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (async assert, sync deassert, handled externally):
  - all outputs 0; FIFO empty; `prev_count` = 0; state IDLE.
- Sample detect:
  - `prev_count` registers `dct_count` every cycle.
  - `new_sample` = (`dct_count` != `prev_count`) AND state==RUN.
  - A wrap from 2^CNT_W−1 to 0 counts as one sample.
  - A jump of >1 still counts as one sample, since only one word is available.
- Write:
  - On `new_sample` with FIFO not full, `dct_buffer` is written.
  - On `new_sample` with FIFO full, the word is dropped and `overflow_cnt` increments, saturating at 2^OVF_W−1.
- Read:
  - `rd_valid` = FIFO not empty, registered output (first-word fall-through from a registered head).
  - A pop occurs when `rd_valid` && `rd_ready`.
  - Write-to-`rd_valid` latency: 1 cycle.
- Simultaneous push and pop:
  - When full, the pop frees a slot the same cycle, so the push is accepted and no overflow is counted.
  - When empty, the push lands and `rd_valid` rises next cycle; no pop occurs.
- `fill_level`: updated the same cycle as the push/pop edge; net 0 on simultaneous push and pop.
- Pointers: $clog2(DEPTH)+1 bits each; full/empty are decoded from the MSB difference.
- FSM:
  - IDLE → RUN: first cycle after reset release. IDLE lasts exactly 1 cycle so the first `prev_count` is valid.
  - RUN → FLUSH: `test_ending`=1. Capture stops the same cycle; a sample coinciding with `test_ending` is dropped and not counted as overflow.
  - FLUSH → DONE: FIFO empty. `flush_done`=1 from the DONE cycle, sticky until reset.
  - Any state → HALT on `test_has_ended`=1 (HALT encoding = 2'b11; IDLE=00, RUN=01, FLUSH=10, DONE is represented by FLUSH && empty, with `flush_done` flagging it).
  - In HALT: no pushes, no pops, `rd_valid` forced 0, counters frozen. HALT is left only by reset.
- `test_ending` deasserting during FLUSH has no effect; FLUSH is irreversible.
- Reset mid-flush: everything clears, including `overflow_cnt` and `flush_done`.
- `rd_ready` may be held high indefinitely. Data is never duplicated or skipped.

Optional Feature:
- Macro: `NIOS_OCI_DCT_PARITY_EN`.
- Defined:
  - each stored word carries an even-parity bit computed at write.
  - `rd_data` is DCT_W+1 wide, with parity in the MSB.
  - an extra output `parity_err` (1-bit, registered) pulses for 1 cycle if the recomputed parity of a popped word mismatches.
- Undefined: `rd_data` is DCT_W wide, and neither parity logic nor the `parity_err` port exists.

Decomposition:
- Package `nios_base_oci_pkg`:
  - state enum (IDLE/RUN/FLUSH/HALT);
  - localparams for default DCT_W/CNT_W;
  - function `clog2_f`.
- One sub-module `nios_base_oci_sync_fifo`:
  - parametrised width and depth;
  - push/pop/full/empty/level;
  - registered head.
- The top holds sample detect, the FSM, overflow and parity.

Test Plan:
1. Reset release, then step `dct_count` 0→1→2→3 with `dct_buffer`=0x0000_0011/22/33. Expect `rd_data` to pop 0x11, 0x22, 0x33 in order with `rd_ready`=1, `fill_level` peak 1, and `overflow_cnt`=0.
2. DEPTH=16, `rd_ready`=0, 20 count increments. Expect `fill_level`=16 and `overflow_cnt`=4; draining then yields the first 16 words only.
3. Full FIFO, `rd_ready`=1 while a new sample arrives in the same cycle. Expect the push to be accepted, `fill_level` to stay 16, and `overflow_cnt` unchanged.
4. `dct_count` wrap 15→0 (CNT_W=4). Expect exactly one sample captured.
5. Assert `test_ending` with 5 entries queued and a concurrent sample. Expect the concurrent sample dropped and 5 pops, then `flush_done`=1 with `state_o`=FLUSH. Further count changes are ignored.
6. Assert `test_has_ended` mid-drain with 3 entries. Expect `rd_valid`=0 and `fill_level` frozen at 3. Then pulse `reset_n` low asynchronously mid-cycle: all outputs 0 immediately.
